riscv_test_controller: RTL and testbench

Synthesizable run controller for the RISC-V processor core, placed between the bench or board harness and the core's clk/reset/result ports. It replaces the fixed reset-then-fixed-delay-then-finish scheme with a parametrised sequence:
- Hold the core in reset for a programmable number of cycles.
- Release the core and count run cycles.
- Watch a result bus of parametrised width for a stable expected value.
- Report pass, or report timeout.

---
 rtl/riscv_tc_pkg.sv | 10 +
 rtl/result_trace_buf.sv | 28 ++
 rtl/riscv_test_controller.sv | 113 +++++++++++
 tb/tb_riscv_test_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_tc_pkg.sv
// riscv_tc_pkg: shared state encoding, widths and saturating increment for the run controller
package riscv_tc_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} tc_state_t;
    localparam int CHG_W = 8;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] m;
        m = 32'hFFFF_FFFF >> (32 - w);
        return v == m ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/result_trace_buf.sv
// result_trace_buf: circular buffer of recent result values; idx 0 reads the newest entry
module result_trace_buf #(
    parameter int RESULT_W = 16,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           wr,
    input  logic [RESULT_W-1:0]            din,
    input  logic [$clog2(TRACE_DEPTH)-1:0] idx,
    output logic [RESULT_W-1:0]            dout
);
    localparam int IW = $clog2(TRACE_DEPTH);
    logic [RESULT_W-1:0] mem [TRACE_DEPTH];
    logic [IW-1:0] ptr;
    // ptr is the next slot to write, so the newest entry sits one behind it
    always_comb dout = mem[ptr - IW'(1) - idx];
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < TRACE_DEPTH; i++) mem[i] <= '0;
            ptr <= '0;
        end else if (wr) begin
            mem[ptr] <= din;
            ptr <= ptr + IW'(1);
        end
    end
endmodule

// File: rtl/riscv_test_controller.sv
// riscv_test_controller: holds the core in reset, runs it, and reports pass on a stable expected result or timeout.
// Optional result trace buffer enabled by defining RESULT_TRACE_EN.
module riscv_test_controller
    import riscv_tc_pkg::*;
#(
    parameter int RESULT_W = 16,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 180,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W = 16,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [RESULT_W-1:0]            expected,
    input  logic [RESULT_W-1:0]            result,
    output logic                           core_reset,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [CNT_W-1:0]               cycle_count,
    output logic [CHG_W-1:0]               change_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [RESULT_W-1:0]            trace_data
);
    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    tc_state_t state;
    logic [HW-1:0] hold_cnt;
    logic [SW-1:0] stable_cnt;
    logic [RESULT_W-1:0] exp_q, prev_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic accept, match, changed, hit, tmo, trace_wr;
    always_comb begin
        accept = start && (state == IDLE || state == DONE);
        match = result == exp_q;
        changed = result != prev_q;
        cnt_nxt = CNT_W'(sat_inc(32'(cycle_count), CNT_W));
        hit = match && (32'(stable_cnt) + 32'd1 == 32'(STABLE_CYCLES));
        tmo = 32'(cnt_nxt) == 32'(TIMEOUT_CYCLES);
        trace_wr = state == RUN && changed;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            core_reset <= 1'b1;
            {busy, done, pass, timeout} <= '0;
            cycle_count <= '0;
            change_count <= '0;
            stable_cnt <= '0;
            hold_cnt <= '0;
            exp_q <= '0;
            prev_q <= '0;
        end else if (accept) begin
            state <= HOLD;
            exp_q <= expected;
            core_reset <= 1'b1;
            busy <= 1'b1;
            {done, pass, timeout} <= '0;
            cycle_count <= '0;
            change_count <= '0;
            stable_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
                        state <= RUN;
                        core_reset <= 1'b0;
                        prev_q <= result;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RUN: begin
                    cycle_count <= cnt_nxt;
                    stable_cnt <= match ? stable_cnt + SW'(1) : '0;
                    if (changed) begin
                        change_count <= CHG_W'(sat_inc(32'(change_count), CHG_W));
                        prev_q <= result;
                    end
                    // pass takes priority when both exits land on the same cycle
                    if (hit || tmo) begin
                        state <= DONE;
                        core_reset <= 1'b1;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= hit;
                        timeout <= !hit;
                    end
                end
                default: ;
            endcase
        end
    end
`ifdef RESULT_TRACE_EN
    result_trace_buf #(.RESULT_W(RESULT_W), .TRACE_DEPTH(TRACE_DEPTH)) u_trace (
        .clk(clk),
        .reset(reset),
        .clear(accept),
        .wr(trace_wr),
        .din(result),
        .idx(trace_idx),
        .dout(trace_data)
    );
`else
    logic unused_trace;
    assign unused_trace = ^{trace_idx, trace_wr};
    assign trace_data = '0;
`endif
endmodule

// File: tb/tb_riscv_test_controller.sv
// tb_riscv_test_controller: directed checks of hold, pass, timeout, glitch, reset/start handling and trace
module tb_riscv_test_controller;
    logic clk = 0, reset = 0, start = 0;
    logic [15:0] expected = 0, result = 0;
    logic [2:0] trace_idx = 0;
    logic core_reset, busy, done, pass, timeout;
    logic [15:0] cycle_count, trace_data;
    logic [7:0] change_count;
    logic core_reset2, busy2, done2, pass2, timeout2;
    logic [15:0] cycle_count2, trace_data2;
    logic [7:0] change_count2;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    riscv_test_controller dut (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .result(result),
        .core_reset(core_reset), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .cycle_count(cycle_count), .change_count(change_count),
        .trace_idx(trace_idx), .trace_data(trace_data)
    );

    riscv_test_controller #(.TIMEOUT_CYCLES(19)) dut2 (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .result(result),
        .core_reset(core_reset2), .busy(busy2), .done(done2), .pass(pass2), .timeout(timeout2),
        .cycle_count(cycle_count2), .change_count(change_count2),
        .trace_idx(trace_idx), .trace_data(trace_data2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start pulse, then confirm core_reset stays high for exactly four edges
    task automatic start_hold(input logic [15:0] e);
        expected = e;
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (core_reset !== 1'b1 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL hold[%0d]: core_reset=%b busy=%b want 1 1", i, core_reset, busy);
            end
            tick();
        end
        n_cmp++;
        if (core_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL release: core_reset=%b want 0", core_reset);
        end
    endtask

    task automatic check_end(input string nm, input logic p, input logic t, input int cc, input int ch);
        n_cmp++;
        if (done !== 1'b1 || pass !== p || timeout !== t || cycle_count !== 16'(cc) || change_count !== 8'(ch)) begin
            n_bad++;
            $display("FAIL %s: done=%b pass=%b timeout=%b cycles=%0d changes=%0d want 1 %b %b %0d %0d",
                     nm, done, pass, timeout, cycle_count, change_count, p, t, cc, ch);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        n_cmp++;
        if ({core_reset, busy, done, pass, timeout} !== 5'b10000 || cycle_count !== 0 || change_count !== 0) begin
            n_bad++;
            $display("FAIL reset: flags=%b cycles=%0d changes=%0d want 10000 0 0",
                     {core_reset, busy, done, pass, timeout}, cycle_count, change_count);
        end
    endtask

    task automatic test_pass();
        result = 16'h0000;
        start_hold(16'h002A);
        for (int k = 0; k < 200 && !done; k++) begin
            result = k >= 10 ? 16'h002A : 16'h0000;
            tick();
        end
        check_end("pass", 1'b1, 1'b0, 18, 1);
    endtask

    task automatic test_timeout();
        result = 16'h0011;
        start_hold(16'h002A);
        for (int k = 0; k < 300 && !done; k++) tick();
        check_end("timeout", 1'b0, 1'b1, 180, 0);
        tick();
        n_cmp++;
        if (core_reset !== 1'b1 || busy !== 1'b0 || timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL after_timeout: core_reset=%b busy=%b timeout=%b want 1 0 1", core_reset, busy, timeout);
        end
    endtask

    task automatic test_glitch();
        result = 16'h0000;
        start_hold(16'h002A);
        for (int k = 0; k < 200 && !done; k++) begin
            result = ((k >= 5 && k <= 9) || k >= 11) ? 16'h002A : 16'h0000;
            tick();
        end
        check_end("glitch", 1'b1, 1'b0, 19, 3);
        n_cmp++;
        if (done2 !== 1'b1 || pass2 !== 1'b1 || timeout2 !== 1'b0 || cycle_count2 !== 16'd19) begin
            n_bad++;
            $display("FAIL priority: done=%b pass=%b timeout=%b cycles=%0d want 1 1 0 19",
                     done2, pass2, timeout2, cycle_count2);
        end
    endtask

    task automatic test_reset_mid_run();
        result = 16'h0000;
        start_hold(16'h002A);
        for (int k = 0; k < 30; k++) tick();
        reset = 1;
        tick();
        reset = 0;
        n_cmp++;
        if ({core_reset, busy, done, pass, timeout} !== 5'b10000 || cycle_count !== 0 || change_count !== 0) begin
            n_bad++;
            $display("FAIL mid_reset: flags=%b cycles=%0d changes=%0d want 10000 0 0",
                     {core_reset, busy, done, pass, timeout}, cycle_count, change_count);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || core_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b core_reset=%b want 0 1", busy, core_reset);
        end
    endtask

    task automatic test_start_busy();
        result = 16'h0000;
        start_hold(16'h002A);
        for (int k = 0; k < 20; k++) tick();
        start = 1;
        expected = 16'h0055;
        tick();
        start = 0;
        n_cmp++;
        if (busy !== 1'b1 || core_reset !== 1'b0 || cycle_count !== 16'd21) begin
            n_bad++;
            $display("FAIL start_busy: busy=%b core_reset=%b cycles=%0d want 1 0 21", busy, core_reset, cycle_count);
        end
        for (int k = 21; k < 200 && !done; k++) begin
            result = 16'h002A;
            tick();
        end
        check_end("start_busy_pass", 1'b1, 1'b0, 29, 1);
    endtask

    task automatic test_restart();
        expected = 16'h0055;
        result = 16'h0055;
        start = 1;
        tick();
        start = 0;
        n_cmp++;
        if ({core_reset, busy, done, pass, timeout} !== 5'b11000 || cycle_count !== 0 || change_count !== 0) begin
            n_bad++;
            $display("FAIL restart: flags=%b cycles=%0d changes=%0d want 11000 0 0",
                     {core_reset, busy, done, pass, timeout}, cycle_count, change_count);
        end
        for (int k = 0; k < 3; k++) tick();
        tick();
        n_cmp++;
        if (core_reset !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_release: core_reset=%b want 0", core_reset);
        end
        for (int k = 0; k < 200 && !done; k++) tick();
        check_end("restart_pass", 1'b1, 1'b0, 8, 0);
    endtask

    task automatic test_trace();
        logic [15:0] want [3];
        logic [2:0] ids [3];
        want = '{16'd10, 16'd9, 16'd3};
        ids = '{3'd0, 3'd1, 3'd7};
        result = 16'h0000;
        start_hold(16'hFFFF);
        for (int k = 0; k < 10; k++) begin
            result = 16'(k + 1);
            tick();
        end
`ifdef RESULT_TRACE_EN
        for (int i = 0; i < 3; i++) begin
            trace_idx = ids[i];
            #1;
            n_cmp++;
            if (trace_data !== want[i]) begin
                n_bad++;
                $display("FAIL trace[%0d]: got %0d want %0d", ids[i], trace_data, want[i]);
            end
        end
`else
        trace_idx = 3'd2;
        #1;
        n_cmp++;
        if (trace_data !== 16'd0) begin
            n_bad++;
            $display("FAIL trace_off: got %0h want 0", trace_data);
        end
`endif
        n_cmp++;
        if (change_count !== 8'd10 || cycle_count !== 16'd10) begin
            n_bad++;
            $display("FAIL trace_changes: changes=%0d cycles=%0d want 10 10", change_count, cycle_count);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_timeout();
        test_glitch();
        test_reset_mid_run();
        test_start_busy();
        test_restart();
        test_trace();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
